instr_encoder: RTL and testbench

- Write-side counterpart of the main control decoder: accepts structured instruction requests (class plus fields) and encodes them into 32-bit MIPS words.
- Buffers encoded words in a small FIFO and streams them into the instruction-memory write port at sequential word addresses.
- Lets the bench or a host load programs without hand-assembled hex.
- Opcode map is identical to the one the decoder consumes, so any word this block writes decodes back to the requested class.

---
 rtl/instr_encoder.sv | 253 +++++++++++++++++++++++++
 tb/tb_instr_encoder.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Write-side counterpart of the control decoder. Structured instruction
// requests (class + fields) are encoded into 32-bit MIPS words, buffered in
// a small FIFO and streamed into the instruction-memory write port at
// sequential word addresses starting from BASE_ADDR.
//
// Optional feature macro: INSTR_ENC_CLASS_CHECK_EN
//   defined   : class_i 11..15 is accepted but dropped, err_o sets sticky
//   undefined : class_i 11..15 encodes as a nop (32'h0) and is written,
//               err_o is tied low
//
// Parameters
//   DEPTH     FIFO entries (power of two, >= 4)
//   ADDR_W    imem byte-address width
//   BASE_ADDR first write address (word aligned)
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               one-cycle pulse, opens (or restarts) a load session
//   valid_i / ready_o     request handshake
//   last_i                request closes the session
//   class_i               instruction class (0 R .. 10 LUI)
//   rs_i rt_i rd_i        register fields
//   shamt_i funct_i       R-type shift amount / function
//   imm_i target_i        immediate / jump target
//   imem_ready_i          memory accepts a write this cycle
//   imem_we_o             write strobe
//   imem_addr_o           byte address of the word on imem_data_o
//   imem_data_o           encoded word (FIFO head)
//   count_o               words written this session
//   done_o                session complete
//   err_o                 sticky illegal-class flag
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              last_i,
  input  logic [3:0]        class_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        shamt_i,
  input  logic [5:0]        funct_i,
  input  logic [15:0]       imm_i,
  input  logic [25:0]       target_i,
  input  logic              imem_ready_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_data_o,
  output logic [ADDR_W-2:0] count_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int CNTO_W  = ADDR_W - 1;

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  // Total occupancy (encode stage + FIFO) at or below this keeps >= 2 free.
  localparam logic [CNT_W-1:0]  OCC_LIMIT = CNT_W'(DEPTH - 2);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BGT  = 6'b000111;
  localparam logic [5:0] OP_BNEZ = 6'b000101;
  localparam logic [5:0] OP_BGEZ = 6'b000001;
  localparam logic [5:0] OP_LUI  = 6'b001111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  // Opcode map shared with the control decoder. Unknown classes encode as nop.
  function automatic logic [31:0] encode(
    input logic [3:0]  cls,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [5:0]  funct,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] w;
    w = 32'h0000_0000;
    case (cls)
      4'd0:    w = {OP_R, rs, rt, rd, shamt, funct};
      4'd1:    w = {OP_ADDI, rs, rt, imm};
      4'd2:    w = {OP_ORI, rs, rt, imm};
      4'd3:    w = {OP_BEQ, rs, rt, imm};
      4'd4:    w = {OP_LW, rs, rt, imm};
      4'd5:    w = {OP_SW, rs, rt, imm};
      4'd6:    w = {OP_J, target};
      4'd7:    w = {OP_BGT, rs, rt, imm};
      4'd8:    w = {OP_BNEZ, rs, 5'd0, imm};
      4'd9:    w = {OP_BGEZ, rs, 5'd0, imm};
      4'd10:   w = {OP_LUI, 5'd0, rt, imm};
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  state_t             state;
  logic               vld_p0;
  logic [31:0]        enc_word_p0;
  logic [31:0]        fifo_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;
  logic [CNT_W-1:0]   fifo_cnt_nxt;
  logic [CNT_W-1:0]   occ_total;
  logic [ADDR_W-1:0]  addr_q;
  logic [CNTO_W-1:0]  count_q;
  logic               done_q;
  logic               accept;
  logic               legal;
  logic               push;
  logic               pop;
  logic               fifo_empty;

  assign fifo_empty = (fifo_cnt == '0);
  assign occ_total  = fifo_cnt + {{(CNT_W-1){1'b0}}, vld_p0};

  // Occupancy counts the word sitting in the encode stage so that the stage
  // always finds room in the FIFO on the following cycle.
  assign ready_o = (state == S_LOAD) && (occ_total <= OCC_LIMIT);

  // start_i wins over a same-cycle request; nothing is accepted or written
  // while a flush (start_i) or reset is in progress.
  assign accept = valid_i && ready_o && !start_i && !rst_i;
  assign push   = vld_p0;
  assign pop    = !fifo_empty && imem_ready_i && !start_i && !rst_i;

  always_comb begin
    fifo_cnt_nxt = fifo_cnt;
    if (push && !pop) begin
      fifo_cnt_nxt = fifo_cnt + CNT_W'(1);
    end else if (pop && !push) begin
      fifo_cnt_nxt = fifo_cnt - CNT_W'(1);
    end
  end

`ifdef INSTR_ENC_CLASS_CHECK_EN
  logic err_q;

  assign legal = (class_i <= 4'd10);

  always_ff @(posedge clk_i) begin
    if (rst_i || start_i) begin
      err_q <= 1'b0;
    end else if (accept && !legal) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign legal = 1'b1;
  assign err_o = 1'b0;
`endif

  // Stage p0: encode register (data, no reset)
  always_ff @(posedge clk_i) begin
    if (accept) begin
      enc_word_p0 <= encode(class_i, rs_i, rt_i, rd_i, shamt_i, funct_i,
                            imm_i, target_i);
    end
  end

  // FIFO storage (data, no reset)
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr] <= enc_word_p0;
    end
  end

  // Control: session FSM, encode-stage valid, FIFO pointers, address/count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      done_q   <= 1'b0;
      vld_p0   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      addr_q   <= BASE;
      count_q  <= '0;
    end else if (start_i) begin
      state    <= S_LOAD;
      done_q   <= 1'b0;
      vld_p0   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      addr_q   <= BASE;
      count_q  <= '0;
    end else begin
      vld_p0   <= accept && legal;
      fifo_cnt <= fifo_cnt_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        addr_q  <= addr_q + ADDR_W'(4);
        count_q <= count_q + CNTO_W'(1);
      end
      case (state)
        S_LOAD: begin
          if (accept && last_i) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // No new requests arrive here, so once the FIFO empties after this
          // cycle's pop (counting any push from the encode stage) we're done.
          if (fifo_cnt_nxt == '0) begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

  assign imem_we_o   = pop;
  assign imem_addr_o = addr_q;
  assign imem_data_o = fifo_empty ? 32'h0000_0000 : fifo_mem[rd_ptr];
  assign count_o     = count_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 10;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic              valid_i;
  logic              ready_o;
  logic              last_i;
  logic [3:0]        class_i;
  logic [4:0]        rs_i;
  logic [4:0]        rt_i;
  logic [4:0]        rd_i;
  logic [4:0]        shamt_i;
  logic [5:0]        funct_i;
  logic [15:0]       imm_i;
  logic [25:0]       target_i;
  logic              imem_ready_i;
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_data_o;
  logic [ADDR_W-2:0] count_o;
  logic              done_o;
  logic              err_o;

  always #5 clk_i = ~clk_i;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .last_i       (last_i),
    .class_i      (class_i),
    .rs_i         (rs_i),
    .rt_i         (rt_i),
    .rd_i         (rd_i),
    .shamt_i      (shamt_i),
    .funct_i      (funct_i),
    .imm_i        (imm_i),
    .target_i     (target_i),
    .imem_ready_i (imem_ready_i),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_data_o  (imem_data_o),
    .count_o      (count_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  typedef struct {
    logic [3:0]  cls;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  int n_cmp  = 0;
  int n_fail = 0;
  int writes_seen = 0;
  wr_t sb[$];
  logic [ADDR_W-1:0] exp_addr;
  vec_t tbl[14];

`ifdef INSTR_ENC_CLASS_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] c, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                              input logic [15:0] imm, input logic [25:0] tg, input logic [31:0] e);
    vec_t v;
    v.cls = c; v.rs = rs; v.rt = rt; v.rd = rd; v.sh = sh;
    v.fn = fn; v.imm = imm; v.tgt = tg; v.exp = e;
    return v;
  endfunction

  // Scoreboard: every write is checked against the oldest expected entry.
  always @(negedge clk_i) begin
    if (imem_we_o === 1'b1) begin
      wr_t w;
      writes_seen++;
      if (sb.size() == 0) begin
        check("spurious_write", {32'd0, imem_data_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        w = sb.pop_front();
        check("wr_addr", imem_addr_o, w.addr);
        check("wr_data", imem_data_o, w.data);
      end
    end
  end

  task automatic drive_vec(input vec_t v, input bit last);
    class_i = v.cls; rs_i = v.rs; rt_i = v.rt; rd_i = v.rd; shamt_i = v.sh;
    funct_i = v.fn; imm_i = v.imm; target_i = v.tgt;
    valid_i = 1'b1; last_i = last;
  endtask

  function automatic bit dropped(input logic [3:0] c);
    return CHECK_EN && (c > 4'd10);
  endfunction

  task automatic expect_word(input vec_t v);
    if (!dropped(v.cls)) begin
      sb.push_back('{exp_addr, v.exp});
      exp_addr = exp_addr + ADDR_W'(4);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input vec_t v, input bit last);
    int t;
    t = 0;
    drive_vec(v, last);
    forever begin
      @(negedge clk_i);
      if (ready_o === 1'b1) break;
      t++;
      if (t > 300) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    if (ready_o === 1'b1) expect_word(v);
    @(posedge clk_i); #1;
    valid_i = 1'b0; last_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    sb.delete();
    exp_addr = '0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (done_o !== 1'b1 && t < 500) begin
      @(negedge clk_i);
      t++;
    end
    check(name, done_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int acc_before_drop;
    int ws0;

    tbl[0]  = mk(4'd0,  5'd3,  5'd4,  5'd5, 5'd0, 6'h20, 16'h0000, 26'h0,       32'h0064_2820);
    tbl[1]  = mk(4'd6,  5'd1,  5'd2,  5'd3, 5'd4, 6'h3F, 16'hAAAA, 26'h000_0010, 32'h0800_0010);
    tbl[2]  = mk(4'd10, 5'd9,  5'd7,  5'd0, 5'd0, 6'h00, 16'h1234, 26'h0,       32'h3C07_1234);
    tbl[3]  = mk(4'd8,  5'd9,  5'd31, 5'd0, 5'd0, 6'h00, 16'hFFFE, 26'h0,       32'h1520_FFFE);
    tbl[4]  = mk(4'd1,  5'd1,  5'd2,  5'd0, 5'd0, 6'h00, 16'h0005, 26'h0,       32'h2022_0005);
    tbl[5]  = mk(4'd2,  5'd2,  5'd3,  5'd0, 5'd0, 6'h00, 16'h00FF, 26'h0,       32'h3443_00FF);
    tbl[6]  = mk(4'd3,  5'd4,  5'd5,  5'd0, 5'd0, 6'h00, 16'h0010, 26'h0,       32'h1085_0010);
    tbl[7]  = mk(4'd4,  5'd29, 5'd8,  5'd0, 5'd0, 6'h00, 16'h0004, 26'h0,       32'h8FA8_0004);
    tbl[8]  = mk(4'd5,  5'd29, 5'd9,  5'd0, 5'd0, 6'h00, 16'h0008, 26'h0,       32'hAFA9_0008);
    tbl[9]  = mk(4'd7,  5'd1,  5'd2,  5'd0, 5'd0, 6'h00, 16'hFFFC, 26'h0,       32'h1C22_FFFC);
    tbl[10] = mk(4'd9,  5'd6,  5'd7,  5'd0, 5'd0, 6'h00, 16'h0003, 26'h0,       32'h04C0_0003);
    tbl[11] = mk(4'd0,  5'd0,  5'd8,  5'd9, 5'd4, 6'h00, 16'h0000, 26'h0,       32'h0008_4900);
    tbl[12] = mk(4'd12, 5'd5,  5'd6,  5'd7, 5'd1, 6'h11, 16'hBEEF, 26'h3FF_FFFF, 32'h0000_0000);
    tbl[13] = mk(4'd6,  5'd0,  5'd0,  5'd0, 5'd0, 6'h00, 16'h0000, 26'h3FF_FFFF, 32'h0BFF_FFFF);

    rst_i = 1'b1; start_i = 1'b0; valid_i = 1'b0; last_i = 1'b0;
    class_i = '0; rs_i = '0; rt_i = '0; rd_i = '0; shamt_i = '0;
    funct_i = '0; imm_i = '0; target_i = '0; imem_ready_i = 1'b1;
    exp_addr = '0;

    // Reset values
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_ready", ready_o, 0);
    check("rst_we", imem_we_o, 0);
    check("rst_addr", imem_addr_o, 0);
    check("rst_data", imem_data_o, 0);
    check("rst_count", count_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    @(posedge clk_i); #1;

    // Single ADDI: latency accept N -> write N+2 -> done N+3
    pulse_start();
    drive_vec(tbl[4], 1'b1);
    @(negedge clk_i);
    check("lat_ready_n", ready_o, 1);
    expect_word(tbl[4]);
    @(posedge clk_i); #1;
    valid_i = 1'b0; last_i = 1'b0;
    @(negedge clk_i);
    check("lat_we_n1", imem_we_o, 0);
    @(negedge clk_i);
    check("lat_we_n2", imem_we_o, 1);
    check("lat_addr_n2", imem_addr_o, 0);
    check("lat_data_n2", imem_data_o, 32'h2022_0005);
    @(negedge clk_i);
    check("lat_done_n3", done_o, 1);
    check("lat_count_n3", count_o, 1);
    check("lat_ready_done", ready_o, 0);
    @(posedge clk_i); #1;

    // Table run: every class back-to-back in one session
    pulse_start();
    check("load_done_low", done_o, 0);
    ws0 = writes_seen;
    for (int i = 0; i < 14; i++) send(tbl[i], i == 13);
    wait_done("tbl_done");
    check("tbl_count", count_o, CHECK_EN ? 13 : 14);
    check("tbl_writes", writes_seen - ws0, CHECK_EN ? 13 : 14);
    check("tbl_sb_empty", sb.size(), 0);
    check("tbl_err", err_o, CHECK_EN ? 1 : 0);
    @(posedge clk_i); #1;

    // Backpressure: 10 requests with memory stalled, then release
    imem_ready_i = 1'b0;
    pulse_start();
    ws0 = writes_seen;
    idx = 0;
    acc_before_drop = -1;
    for (int cyc = 0; cyc < 300 && idx < 10; cyc++) begin
      if (cyc == 12) imem_ready_i = 1'b1;
      drive_vec(tbl[idx], idx == 9);
      @(negedge clk_i);
      if (cyc == 11) begin
        check("bp_hold_we", imem_we_o, 0);
        check("bp_hold_addr", imem_addr_o, 0);
        check("bp_hold_data", imem_data_o, tbl[0].exp);
      end
      if (ready_o === 1'b1) begin
        expect_word(tbl[idx]);
        idx++;
      end else if (acc_before_drop < 0) begin
        acc_before_drop = idx;
      end
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0; last_i = 1'b0;
    check("bp_accepts_before_drop", acc_before_drop, 7);
    wait_done("bp_done");
    check("bp_count", count_o, 10);
    check("bp_writes", writes_seen - ws0, 10);
    check("bp_sb_empty", sb.size(), 0);
    @(posedge clk_i); #1;

    // Abort mid-session with 3 words buffered
    imem_ready_i = 1'b0;
    pulse_start();
    for (int i = 0; i < 3; i++) send(tbl[i], 1'b0);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    check("abort_pre_data", imem_data_o, tbl[0].exp);
    start_i = 1'b1;
    sb.delete();
    exp_addr = '0;
    imem_ready_i = 1'b1;
    @(negedge clk_i);
    check("abort_we_start", imem_we_o, 0);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("abort_count", count_o, 0);
    check("abort_addr", imem_addr_o, 0);
    ws0 = writes_seen;
    repeat (3) @(negedge clk_i);
    check("abort_no_writes", writes_seen - ws0, 0);
    @(posedge clk_i); #1;
    send(tbl[3], 1'b1);
    wait_done("abort_done");
    check("abort_count_after", count_o, 1);
    check("abort_writes", writes_seen - ws0, 1);
    @(posedge clk_i); #1;

    // Illegal class on its own
    pulse_start();
    ws0 = writes_seen;
    send(tbl[12], 1'b1);
    wait_done("ill_done");
    check("ill_count", count_o, CHECK_EN ? 0 : 1);
    check("ill_writes", writes_seen - ws0, CHECK_EN ? 0 : 1);
    check("ill_err", err_o, CHECK_EN ? 1 : 0);
    @(posedge clk_i); #1;

    // Reset mid-session discards buffered words
    imem_ready_i = 1'b0;
    pulse_start();
    send(tbl[0], 1'b0);
    send(tbl[1], 1'b0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    imem_ready_i = 1'b1;
    sb.delete();
    ws0 = writes_seen;
    @(negedge clk_i);
    check("mrst_we", imem_we_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("mrst_ready", ready_o, 0);
    check("mrst_count", count_o, 0);
    check("mrst_done", done_o, 0);
    check("mrst_addr", imem_addr_o, 0);
    check("mrst_data", imem_data_o, 0);
    repeat (3) @(negedge clk_i);
    check("mrst_no_writes", writes_seen - ws0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
